cci_mpf_tx_chan_buf: RTL and testbench
======================================

# cci_mpf_tx_chan_buf

Parametrised multi-channel request buffer for the MPF transmit path, placed between AFU-side request producers and the FIU-side Tx channels. Each of N_CHAN channels gets an independent FIFO. The block honours the FIU's almost-full flow control and generates its own almost-full toward the AFU with a configurable slack. It generalises the fixed two-channel c0Tx/c1Tx request/almost-full pairing to any channel count, payload width and buffer depth, and adds occupancy reporting and sticky overflow detection.

## Interface

Parameters
- N_CHAN, 2: number of independent Tx channels.
- DATA_WIDTH, 600: request payload bits per channel.
- DEPTH, 16: FIFO entries per channel; power of two, >= 4.
- ALM_FULL_SLACK, 4: free entries remaining when afu_tx_alm_full asserts; 2 <= ALM_FULL_SLACK < DEPTH.

Ports
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- afu_tx_valid  in  N_CHAN  request strobe per channel, one request per cycle when high.
- afu_tx_data  in  N_CHAN*DATA_WIDTH  payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- afu_tx_alm_full  out  N_CHAN  per-channel almost-full toward the AFU.
- fiu_tx_valid  out  N_CHAN  registered request strobe toward the FIU.
- fiu_tx_data  out  N_CHAN*DATA_WIDTH  registered payload toward the FIU.
- fiu_tx_alm_full  in  N_CHAN  FIU almost-full; the block stops issuing on a channel while this is high.
- occupancy  out  N_CHAN*$clog2(DEPTH+1)  per-channel FIFO entry count, registered.
- overflow_err  out  N_CHAN  sticky flag: a request was dropped on this channel.

## Operation

- Channels are fully independent. There is no shared arbitration, and no event on channel i affects channel j.
- Enqueue: afu_tx_valid[i]=1 writes afu_tx_data slice i at the FIFO tail on that clock edge.
- Dequeue decision, made each cycle per channel: dequeue if count[i] > 0 and fiu_tx_alm_full[i] == 0 in that cycle.
  - On dequeue, the head entry is loaded into the output register, and fiu_tx_valid[i]=1 for exactly the next cycle.
  - With no dequeue, fiu_tx_valid[i]=0 next cycle and fiu_tx_data holds its last value.
- Count update: count' = count + enq_accepted - deq.
  - Width is $clog2(DEPTH+1).
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Full handling:
  - Enqueue while count == DEPTH and dequeue in the same cycle: accepted, count unchanged.
  - Enqueue while count == DEPTH and no dequeue: request dropped, FIFO untouched, overflow_err[i] set.
  - overflow_err[i] stays set until reset.
- Empty handling: simultaneous enqueue and count == 0 produces no dequeue that cycle (no bypass). The entry is eligible next cycle.
- Almost-full: afu_tx_alm_full[i] is registered, and equals (count' >= DEPTH - ALM_FULL_SLACK) computed on the next-state count.
- Ordering: requests leave each channel in strict arrival order.
- Mid-operation reset: all FIFO contents are discarded, pointers and counts go to 0, and in-flight output-register requests are lost.

## Timing

Reset values
- fiu_tx_valid = 0
- fiu_tx_data = 0
- occupancy = 0
- overflow_err = 0
- afu_tx_alm_full = all ones (not ready).
  - It deasserts on the first rising clk edge after reset_n deasserts.
  - It can rise again later only on threshold.

Latency
- Enqueue at edge t → count visible in cycle t+1 → fiu_tx_valid high in cycle t+2 (minimum latency 2 cycles).

Throughput and FIU flow control
- Sustained throughput is 1 request/cycle/channel while fiu_tx_alm_full is low.
- fiu_tx_alm_full is sampled combinationally into the dequeue decision. A high value in cycle t guarantees fiu_tx_valid=0 in cycle t+1.
- At most the request already in the output register can be issued after the FIU raises almost-full.

AFU flow control
- The AFU must stop issuing within ALM_FULL_SLACK-1 cycles of seeing afu_tx_alm_full. The slack covers the one-cycle register lag.

Occupancy
- occupancy reflects count after the edge: it equals count in the same cycle the FIFO state is valid.

## Test plan

- Reset release: hold reset_n=0 for 3 cycles, then release.
  - During reset: all outputs zero except afu_tx_alm_full = all ones.
  - One edge after release: afu_tx_alm_full = 0.
- Single request latency: afu_tx_valid[0]=1 with data 0xA5 at edge t.
  - Required: fiu_tx_valid[0]=1 with data 0xA5 only in cycle t+2.
  - Required: occupancy[0] = 1 in cycle t+1 and 0 in cycle t+2.
  - Required: channel 1 stays idle.
- FIU backpressure fill (DEPTH=16, SLACK=4): hold fiu_tx_alm_full[1]=1 and enqueue 12 requests back-to-back on channel 1.
  - Required: afu_tx_alm_full[1]=1 in the cycle after the 12th enqueue.
  - Required: no fiu_tx_valid[1].
  - Drop backpressure: 12 requests emerge in order, one per cycle.
- Overflow: with fiu_tx_alm_full[0]=1, enqueue 17 requests.
  - Required: occupancy[0]=16 and overflow_err[0]=1, persisting.
  - After release: exactly entries 1–16 emerge.
- Full with simultaneous dequeue: at count 16 with the FIU released, enqueue every cycle for 20 cycles.
  - Required: no overflow_err.
  - Required: count stays 16.
  - Required: continuous fiu_tx_valid.
- Reset mid-stream: assert reset_n=0 asynchronously with 8 entries queued on each channel.
  - Required: outputs reset immediately, not at the next edge.
  - Required: after release, no stale requests emerge and the pointers wrap correctly on a subsequent 40-request stream.

Source files
------------

// File: rtl/cci_mpf_tx_chan_buf.sv
// Multi-channel Tx request buffer: one independent FIFO per channel between AFU
// producers and FIU Tx channels, honouring FIU almost-full and raising AFU almost-full.
module cci_mpf_tx_chan_buf #(
   parameter int N_CHAN         = 2,
   parameter int DATA_WIDTH     = 600,
   parameter int DEPTH          = 16,
   parameter int ALM_FULL_SLACK = 4
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [N_CHAN-1:0]                   afu_tx_valid,
   input  logic [N_CHAN*DATA_WIDTH-1:0]        afu_tx_data,
   output logic [N_CHAN-1:0]                   afu_tx_alm_full,
   output logic [N_CHAN-1:0]                   fiu_tx_valid,
   output logic [N_CHAN*DATA_WIDTH-1:0]        fiu_tx_data,
   input  logic [N_CHAN-1:0]                   fiu_tx_alm_full,
   output logic [N_CHAN*$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [N_CHAN-1:0]                   overflow_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - ALM_FULL_SLACK);

   generate
      for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
         logic [DATA_WIDTH-1:0] mem [DEPTH];
         logic [PW-1:0]         wr_ptr_reg;
         logic [PW-1:0]         rd_ptr_reg;
         logic [CW-1:0]         count_reg;
         logic [CW-1:0]         count_next;
         logic [DATA_WIDTH-1:0] data_reg;
         logic                  valid_reg;
         logic                  alm_full_reg;
         logic                  overflow_reg;
         logic                  full;
         logic                  deq;
         logic                  enq_ok;

         // No bypass: an entry written this edge is only visible to the dequeue next cycle.
         always_comb begin
            full       = (count_reg == FULL_CNT);
            deq        = (count_reg != '0) && !fiu_tx_alm_full[gi];
            enq_ok     = afu_tx_valid[gi] && (!full || deq);
            count_next = count_reg + CW'(enq_ok) - CW'(deq);
         end

         always_ff @(posedge clk) begin
            if (enq_ok)
               mem[wr_ptr_reg] <= afu_tx_data[gi*DATA_WIDTH +: DATA_WIDTH];
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               wr_ptr_reg   <= '0;
               rd_ptr_reg   <= '0;
               count_reg    <= '0;
               data_reg     <= '0;
               valid_reg    <= 1'b0;
               alm_full_reg <= 1'b1;
               overflow_reg <= 1'b0;
            end else begin
               count_reg    <= count_next;
               valid_reg    <= deq;
               alm_full_reg <= (count_next >= AF_THRESH);
               if (enq_ok)
                  wr_ptr_reg <= wr_ptr_reg + PW'(1);
               if (deq) begin
                  rd_ptr_reg <= rd_ptr_reg + PW'(1);
                  data_reg   <= mem[rd_ptr_reg];
               end
               if (afu_tx_valid[gi] && full && !deq)
                  overflow_reg <= 1'b1;
            end
         end

         assign fiu_tx_valid[gi]                         = valid_reg;
         assign fiu_tx_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
         assign afu_tx_alm_full[gi]                      = alm_full_reg;
         assign occupancy[gi*CW +: CW]                   = count_reg;
         assign overflow_err[gi]                         = overflow_reg;
      end
   endgenerate

endmodule

// File: tb/tb_cci_mpf_tx_chan_buf.sv
// Scoreboard bench for cci_mpf_tx_chan_buf: queue-based reference model predicts
// every issued request, occupancy, almost-full and overflow per channel.
module tb_cci_mpf_tx_chan_buf;
   localparam int N     = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int SLACK = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      afu_tx_valid;
   logic [N*DW-1:0]   afu_tx_data;
   logic [N-1:0]      afu_tx_alm_full;
   logic [N-1:0]      fiu_tx_valid;
   logic [N*DW-1:0]   fiu_tx_data;
   logic [N-1:0]      fiu_tx_alm_full;
   logic [N*CW-1:0]   occupancy;
   logic [N-1:0]      overflow_err;

   always #5 clk = ~clk;

   cci_mpf_tx_chan_buf #(
      .N_CHAN(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALM_FULL_SLACK(SLACK)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .afu_tx_valid(afu_tx_valid), .afu_tx_data(afu_tx_data),
      .afu_tx_alm_full(afu_tx_alm_full),
      .fiu_tx_valid(fiu_tx_valid), .fiu_tx_data(fiu_tx_data),
      .fiu_tx_alm_full(fiu_tx_alm_full),
      .occupancy(occupancy), .overflow_err(overflow_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          expq [N][$];
   logic [DW-1:0] mfifo [N][$];
   logic [DW-1:0] m_last [N];
   logic          m_af [N];
   logic          m_ovf [N];
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s ch%0d cyc=%0d actual=%0h required=%0h", name, ch, cyc, act, req);
      end
   endtask

   task automatic model_clear();
      for (int ch = 0; ch < N; ch++) begin
         expq[ch].delete();
         mfifo[ch].delete();
         m_last[ch] = '0;
         m_af[ch]   = 1'b1;
         m_ovf[ch]  = 1'b0;
      end
   endtask

   // Reference behaviour at a rising edge: pop head if present and FIU not almost-full,
   // then append the new request if there was room (or room is being freed).
   task automatic model_step();
      cyc++;
      if (!reset_n) begin
         model_clear();
      end else begin
         for (int ch = 0; ch < N; ch++) begin
            bit   deq;
            bit   was_full;
            exp_t e;
            deq      = (mfifo[ch].size() > 0) && !fiu_tx_alm_full[ch];
            was_full = (mfifo[ch].size() == DEPTH);
            if (deq) begin
               e.data = mfifo[ch].pop_front();
               e.due  = cyc;
               expq[ch].push_back(e);
               m_last[ch] = e.data;
            end
            if (afu_tx_valid[ch]) begin
               if (!was_full || deq) mfifo[ch].push_back(afu_tx_data[ch*DW +: DW]);
               else                  m_ovf[ch] = 1'b1;
            end
            m_af[ch] = (mfifo[ch].size() >= DEPTH - SLACK);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Monitor: one line per issued request, compared against the scoreboard queue.
   initial begin
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < N; ch++) begin
            if (fiu_tx_valid[ch]) begin
               if (expq[ch].size() == 0) begin
                  chk("unexpected_valid", ch, 64'(fiu_tx_valid[ch]), 64'd0);
               end else begin
                  exp_t e;
                  e = expq[ch].pop_front();
                  $display("txn ch%0d cyc=%0d data=%0h", ch, cyc, fiu_tx_data[ch*DW +: DW]);
                  chk("issue_data", ch, 64'(fiu_tx_data[ch*DW +: DW]), 64'(e.data));
                  chk("issue_cycle", ch, 64'(cyc), 64'(e.due));
               end
            end else begin
               if (expq[ch].size() > 0 && expq[ch][0].due <= cyc) begin
                  void'(expq[ch].pop_front());
                  chk("missing_valid", ch, 64'(fiu_tx_valid[ch]), 64'd1);
               end
               chk("data_hold", ch, 64'(fiu_tx_data[ch*DW +: DW]), 64'(m_last[ch]));
            end
            chk("occupancy", ch, 64'(occupancy[ch*CW +: CW]), 64'(mfifo[ch].size()));
            chk("afu_alm_full", ch, 64'(afu_tx_alm_full[ch]), 64'(m_af[ch]));
            chk("overflow_err", ch, 64'(overflow_err[ch]), 64'(m_ovf[ch]));
         end
      end
   end

   initial begin
      reset_n         = 1'b0;
      afu_tx_valid    = '0;
      afu_tx_data     = '0;
      fiu_tx_alm_full = '0;
      model_clear();
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();

      // Single request latency on channel 0.
      afu_tx_valid[0]      = 1'b1;
      afu_tx_data[0 +: DW] = 32'hA5;
      tick();
      afu_tx_valid = '0;
      repeat (4) tick();

      // Fill channel 1 behind FIU backpressure, then drain.
      fiu_tx_alm_full[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         afu_tx_valid[1]       = 1'b1;
         afu_tx_data[DW +: DW] = 32'h1000 + 32'(i);
         tick();
      end
      afu_tx_valid = '0;
      repeat (3) tick();
      fiu_tx_alm_full[1] = 1'b0;
      repeat (16) tick();

      // Overflow channel 0 with 17 requests; entries 1..16 must emerge.
      fiu_tx_alm_full[0] = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         afu_tx_valid[0]      = 1'b1;
         afu_tx_data[0 +: DW] = 32'h2000 + 32'(i);
         tick();
      end
      afu_tx_valid = '0;
      repeat (3) tick();
      fiu_tx_alm_full[0] = 1'b0;
      repeat (20) tick();

      // Clear the sticky flag, then run full with simultaneous dequeue.
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      fiu_tx_alm_full[0] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         afu_tx_valid[0]      = 1'b1;
         afu_tx_data[0 +: DW] = 32'h3000 + 32'(i);
         tick();
      end
      fiu_tx_alm_full[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         afu_tx_valid[0]      = 1'b1;
         afu_tx_data[0 +: DW] = 32'h3100 + 32'(i);
         tick();
      end
      afu_tx_valid = '0;
      repeat (20) tick();

      // Mid-stream asynchronous reset with 8 entries queued per channel.
      fiu_tx_alm_full = '1;
      for (int i = 0; i < 8; i++) begin
         afu_tx_valid = '1;
         for (int ch = 0; ch < N; ch++) afu_tx_data[ch*DW +: DW] = 32'h4000 + 32'(ch*256 + i);
         tick();
      end
      afu_tx_valid = '0;
      tick();
      #2 reset_n = 1'b0;
      #1;
      for (int ch = 0; ch < N; ch++) begin
         chk("async_rst_valid", ch, 64'(fiu_tx_valid[ch]), 64'd0);
         chk("async_rst_data", ch, 64'(fiu_tx_data[ch*DW +: DW]), 64'd0);
         chk("async_rst_occupancy", ch, 64'(occupancy[ch*CW +: CW]), 64'd0);
         chk("async_rst_alm_full", ch, 64'(afu_tx_alm_full[ch]), 64'd1);
      end
      model_clear();
      repeat (2) tick();
      reset_n         = 1'b1;
      fiu_tx_alm_full = '0;
      tick();

      // 40-request stream per channel with random FIU backpressure.
      for (int i = 0; i < 40; i++) begin
         afu_tx_valid = '1;
         for (int ch = 0; ch < N; ch++) begin
            afu_tx_data[ch*DW +: DW] = 32'h5000 + 32'(ch*256 + i);
            fiu_tx_alm_full[ch]      = ($urandom_range(0, 3) == 0);
         end
         tick();
      end
      afu_tx_valid    = '0;
      fiu_tx_alm_full = '0;
      repeat (20) tick();

      // Random traffic with an AFU that honours almost-full.
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < N; ch++) begin
            afu_tx_valid[ch]         = ($urandom_range(0, 2) != 0) && !afu_tx_alm_full[ch];
            afu_tx_data[ch*DW +: DW] = $urandom;
            fiu_tx_alm_full[ch]      = ($urandom_range(0, 4) < 2);
         end
         tick();
      end
      afu_tx_valid    = '0;
      fiu_tx_alm_full = '0;
      repeat (25) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
